mem2_port_arbiter: RTL and testbench

Arbitrates the shared data port of the OTTER memory (port 2: MEM_RDEN2/MEM_WE2/MEM_ADDR2/MEM_DIN2/MEM_SIZE/MEM_SIGN/MEM_DOUT2) between two requesters: requester 0 is the multicycle CPU load/store path, requester 1 is a DMA/debug master. It sits between the CPU's load/store controls and the Memory block. It sequences each grant, tracks the synchronous-read latency and returns read data with a valid pulse. Fairness is round-robin.

---
 rtl/mem2_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem2_port_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem2_port_arbiter.sv
// Round-robin arbiter for the shared OTTER memory data port (port 2).
// Requester 0 is the CPU load/store path, requester 1 a DMA/debug master.
module mem2_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [1:0]        SIZE0,
    input  logic              SIGN0,
    output logic              GNT0,
    output logic              RVALID0,
    input  logic              REQ1,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA1,
    input  logic [1:0]        SIZE1,
    input  logic              SIGN1,
    output logic              GNT1,
    output logic              RVALID1,
    output logic [DATA_W-1:0] RDATA,
    output logic              MEM_RDEN2,
    output logic              MEM_WE2,
    output logic [ADDR_W-1:0] MEM_ADDR2,
    output logic [DATA_W-1:0] MEM_DIN2,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGN,
    input  logic [DATA_W-1:0] MEM_DOUT2,
    output logic              BUSY
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    state_t            state_q, state_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic              owner_q, owner_d;
    logic              prio_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [DATA_W-1:0] rdata_q;

    logic              last_rd, can_gnt, any_gnt, rd_gnt;
    logic              sel_we, sel_sign;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;
    logic [1:0]        sel_size;

    // The final RD_WAIT cycle both returns data and accepts the next grant.
    assign last_rd = (state_q == RD_WAIT) && (lat_cnt_q == 3'd1);
    assign can_gnt = (state_q == IDLE) || last_rd;
    assign GNT0    = can_gnt & REQ0 & (~REQ1 | ~prio_q);
    assign GNT1    = can_gnt & REQ1 & (~REQ0 | prio_q);
    assign any_gnt = GNT0 | GNT1;

    assign sel_we   = GNT1 ? WE1    : WE0;
    assign sel_addr = GNT1 ? ADDR1  : ADDR0;
    assign sel_din  = GNT1 ? WDATA1 : WDATA0;
    assign sel_size = GNT1 ? SIZE1  : SIZE0;
    assign sel_sign = GNT1 ? SIGN1  : SIGN0;
    assign rd_gnt   = any_gnt & ~sel_we;

    assign MEM_WE2   = any_gnt & sel_we;
    assign MEM_RDEN2 = rd_gnt;
    assign MEM_ADDR2 = any_gnt ? sel_addr : addr_q;
    assign MEM_DIN2  = any_gnt ? sel_din  : din_q;
    assign MEM_SIZE  = any_gnt ? sel_size : size_q;
    assign MEM_SIGN  = any_gnt ? sel_sign : sign_q;

    assign RVALID0 = last_rd & ~owner_q;
    assign RVALID1 = last_rd & owner_q;
    assign RDATA   = last_rd ? MEM_DOUT2 : rdata_q;
    assign BUSY    = (state_q == RD_WAIT);

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
        if (rd_gnt) begin
            state_d   = RD_WAIT;
            lat_cnt_d = LAT_INIT;
            owner_d   = GNT1;
        end else if (state_q == RD_WAIT) begin
            if (last_rd) begin
                state_d   = IDLE;
                lat_cnt_d = 3'd0;
            end else begin
                lat_cnt_d = lat_cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            lat_cnt_q <= 3'd0;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            size_q    <= 2'd0;
            sign_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            owner_q   <= owner_d;
            if (any_gnt) begin
                prio_q <= GNT0;
                addr_q <= sel_addr;
                din_q  <= sel_din;
                size_q <= sel_size;
                sign_q <= sel_sign;
            end
            if (last_rd) rdata_q <= MEM_DOUT2;
        end
    end

endmodule

// File: tb/tb_mem2_port_arbiter.sv
// Directed bench for mem2_port_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// both driven by the same requester stimulus.
module tb_mem2_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0, WE0, SIGN0, REQ1, WE1, SIGN1;
    logic [31:0] ADDR0, WDATA0, ADDR1, WDATA1, DOUT;
    logic [1:0]  SIZE0, SIZE1;

    logic        g0_a, g1_a, rv0_a, rv1_a, rden_a, we_a, sign_a, busy_a;
    logic [31:0] rdata_a, addr_a, din_a;
    logic [1:0]  size_a;
    logic        g0_b, g1_b, rv0_b, rv1_b, rden_b, we_b, sign_b, busy_b;
    logic [31:0] rdata_b, addr_b, din_b;
    logic [1:0]  size_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    mem2_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) d1 (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .SIZE0(SIZE0), .SIGN0(SIGN0),
        .GNT0(g0_a), .RVALID0(rv0_a),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .SIZE1(SIZE1), .SIGN1(SIGN1),
        .GNT1(g1_a), .RVALID1(rv1_a), .RDATA(rdata_a),
        .MEM_RDEN2(rden_a), .MEM_WE2(we_a), .MEM_ADDR2(addr_a), .MEM_DIN2(din_a),
        .MEM_SIZE(size_a), .MEM_SIGN(sign_a), .MEM_DOUT2(DOUT), .BUSY(busy_a)
    );

    mem2_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) d3 (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .SIZE0(SIZE0), .SIGN0(SIGN0),
        .GNT0(g0_b), .RVALID0(rv0_b),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .SIZE1(SIZE1), .SIGN1(SIGN1),
        .GNT1(g1_b), .RVALID1(rv1_b), .RDATA(rdata_b),
        .MEM_RDEN2(rden_b), .MEM_WE2(we_b), .MEM_ADDR2(addr_b), .MEM_DIN2(din_b),
        .MEM_SIZE(size_b), .MEM_SIGN(sign_b), .MEM_DOUT2(DOUT), .BUSY(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked at the falling edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        REQ0 = 0; WE0 = 0; ADDR0 = 0; WDATA0 = 0; SIZE0 = 0; SIGN0 = 0;
        REQ1 = 0; WE1 = 0; ADDR1 = 0; WDATA1 = 0; SIZE1 = 0; SIGN1 = 0;
        DOUT = 0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_gnt0", g0_a, 0);     chk("rst_gnt1", g1_a, 0);
        chk("rst_rv0", rv0_a, 0);     chk("rst_rv1", rv1_a, 0);
        chk("rst_rden", rden_a, 0);   chk("rst_we", we_a, 0);
        chk("rst_busy", busy_a, 0);   chk("rst_addr", addr_a, 0);
        chk("rst_din", din_a, 0);     chk("rst_size", size_a, 0);
        chk("rst_sign", sign_a, 0);   chk("rst_rdata", rdata_a, 0);
        chk("rst_busy3", busy_b, 0);
        @(posedge CLK); #1 RESET = 1'b1;

        // single write from requester 0
        cyc(); REQ0 = 1; WE0 = 1; ADDR0 = 32'h6000; WDATA0 = 32'hDEADBEEF; SIZE0 = 2'd2; SIGN0 = 1;
        @(negedge CLK);
        chk("wr_gnt0", g0_a, 1);      chk("wr_gnt1", g1_a, 0);
        chk("wr_we", we_a, 1);        chk("wr_rden", rden_a, 0);
        chk("wr_addr", addr_a, 32'h6000);
        chk("wr_din", din_a, 32'hDEADBEEF);
        chk("wr_size", size_a, 2);    chk("wr_sign", sign_a, 1);
        chk("wr_busy", busy_a, 0);    chk("wr_gnt0_l3", g0_b, 1);
        cyc(); REQ0 = 0;
        @(negedge CLK);
        chk("idle_gnt0", g0_a, 0);    chk("idle_we", we_a, 0);
        chk("idle_addr_hold", addr_a, 32'h6000);
        chk("idle_din_hold", din_a, 32'hDEADBEEF);

        // read from requester 1, RD_LAT=1
        cyc(); REQ1 = 1; WE1 = 0; ADDR1 = 32'h100; SIZE1 = 2'd2; SIGN1 = 0;
        @(negedge CLK);
        chk("rd_gnt1", g1_a, 1);      chk("rd_rden", rden_a, 1);
        chk("rd_we", we_a, 0);        chk("rd_addr", addr_a, 32'h100);
        chk("rd_rv0", rv0_a, 0);      chk("rd_rv1_early", rv1_a, 0);
        cyc(); REQ1 = 0; DOUT = 32'h12345678;
        @(negedge CLK);
        chk("rd_rv1", rv1_a, 1);      chk("rd_rv0_n1", rv0_a, 0);
        chk("rd_rdata", rdata_a, 32'h12345678);
        chk("rd_busy", busy_a, 1);
        cyc(); DOUT = 32'h0BADF00D;
        @(negedge CLK);
        chk("rd_rv1_done", rv1_a, 0); chk("rd_busy_done", busy_a, 0);
        chk("rd_rdata_hold", rdata_a, 32'h12345678);
        repeat (3) cyc();
        DOUT = 0;

        // both requesters streaming writes: alternate starting with 0
        cyc(); REQ0 = 1; WE0 = 1; ADDR0 = 32'hA0; REQ1 = 1; WE1 = 1; ADDR1 = 32'hB0;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) cyc();
            @(negedge CLK);
            chk($sformatf("rr_gnt0_%0d", i), g0_a, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_gnt1_%0d", i), g1_a, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("rr_addr_%0d", i), addr_a, (i % 2 == 0) ? 32'hA0 : 32'hB0);
        end
        cyc(); REQ0 = 0; REQ1 = 0;
        cyc();

        // RD_LAT=3: read by 0 while a write by 1 is pending
        cyc(); REQ0 = 1; WE0 = 0; ADDR0 = 32'h200; REQ1 = 1; WE1 = 1; ADDR1 = 32'h280;
        @(negedge CLK);
        chk("l3_gnt0", g0_b, 1);      chk("l3_gnt1_n", g1_b, 0);
        chk("l3_rden", rden_b, 1);
        cyc(); REQ0 = 0;
        @(negedge CLK);
        chk("l3_gnt1_n1", g1_b, 0);   chk("l3_busy_n1", busy_b, 1);
        chk("l3_rv0_n1", rv0_b, 0);   chk("l3_we_n1", we_b, 0);
        cyc();
        @(negedge CLK);
        chk("l3_gnt1_n2", g1_b, 0);   chk("l3_rv0_n2", rv0_b, 0);
        cyc(); DOUT = 32'hCAFEF00D;
        @(negedge CLK);
        chk("l3_rv0_n3", rv0_b, 1);   chk("l3_rv1_n3", rv1_b, 0);
        chk("l3_rdata", rdata_b, 32'hCAFEF00D);
        chk("l3_gnt1_n3", g1_b, 1);   chk("l3_we_n3", we_b, 1);
        chk("l3_addr_n3", addr_b, 32'h280);
        cyc(); REQ1 = 0; DOUT = 0;
        @(negedge CLK);
        chk("l3_rv0_n4", rv0_b, 0);   chk("l3_busy_n4", busy_b, 0);
        chk("l3_rdata_hold", rdata_b, 32'hCAFEF00D);
        cyc();

        // reset in the cycle after a read grant drops the read
        cyc(); REQ0 = 1; WE0 = 0; ADDR0 = 32'h500;
        @(negedge CLK);
        chk("rr_rdgnt", g0_a, 1);     chk("rr_rdgnt_l3", g0_b, 1);
        cyc(); REQ0 = 0; RESET = 1'b0; DOUT = 32'h55;
        @(negedge CLK);
        chk("rr_rv0", rv0_a, 0);      chk("rr_busy", busy_a, 0);
        chk("rr_rv0_l3", rv0_b, 0);   chk("rr_busy_l3", busy_b, 0);
        chk("rr_rdata", rdata_a, 0);
        cyc(); RESET = 1'b1;
        @(negedge CLK);
        chk("rr_rv0_after", rv0_b, 0); chk("rr_busy_after", busy_b, 0);

        // requester 1 alone: grants on consecutive cycles
        for (int i = 0; i < 5; i++) begin
            cyc(); REQ1 = 1; WE1 = 1; ADDR1 = 32'h300 + 32'(i * 4); WDATA1 = 32'(i);
            @(negedge CLK);
            chk($sformatf("b2b_gnt1_%0d", i), g1_a, 1);
            chk($sformatf("b2b_gnt1_l3_%0d", i), g1_b, 1);
            chk($sformatf("b2b_addr_%0d", i), addr_a, 32'h300 + 32'(i * 4));
            chk($sformatf("b2b_gnt0_%0d", i), g0_a, 0);
        end
        cyc(); REQ1 = 0;
        @(negedge CLK);
        chk("b2b_end_gnt1", g1_a, 0); chk("b2b_end_we", we_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
